// File: rtl/mips_rf_pkg.sv
// Shared constants and types for the scoreboarded MIPS register file.
package mips_rf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;

    // Register 0 always reads as zero and is never busy.
    localparam int ZERO_REG = 0;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] rf_word_t;

    // True when a register address selects the hardwired zero register.
    function automatic logic is_zero_reg(input int unsigned addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/mips_rf_word.sv
// One architectural register plus its pending-write scoreboard bit.
module mips_rf_word
    import mips_rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  mark_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  pending_out
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pending_d;
    logic                  pending_q;

    // Next-state: a write clears the pending bit; a mark (younger instruction) wins over it.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        data_d    = data_q;
        pending_d = pending_q;
        if (wr_en) begin
            data_d    = wr_data;
            pending_d = 1'b0;
        end
        if (mark_en) begin
            pending_d = 1'b1;
        end
    end

    // State register with synchronous reset that overrides any write or mark in the same cycle.
    always_ff @(posedge clock) begin
        // NOTE: this storage is individual flops, not a RAM macro, so clearing it on reset is legal and cheap.
        if (reset) begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            data_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign data_out    = data_q;
    assign pending_out = pending_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// Parametrised MIPS register file: two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MarkPending,
    input  logic [ADDR_WIDTH-1:0] MarkAddr,
    input  logic [ADDR_WIDTH-1:0] SelA,
    input  logic [ADDR_WIDTH-1:0] SelB,
    output logic [DATA_WIDTH-1:0] OutA,
    output logic [DATA_WIDTH-1:0] OutB,
    output logic                  BusyA,
    output logic                  BusyB,
    output logic                  AnyBusy
);

    logic [DATA_WIDTH-1:0] reg_data [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;

    // Register 0 is a constant: no storage, never busy.
    assign reg_data[ZERO_REG] = '0;
    assign pending[ZERO_REG]  = 1'b0;

    // Storage for registers 1..NUM_REGS-1, each with its own decoded enables.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);

        logic wr_en;
        logic mark_en;

        assign wr_en   = RegWrite    && (WriteAddr == IDX);
        assign mark_en = MarkPending && (MarkAddr  == IDX);

        mips_rf_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clock       (clock),
            .reset       (reset),
            .wr_en       (wr_en),
            .wr_data     (WriteData),
            .mark_en     (mark_en),
            .data_out    (reg_data[i]),
            .pending_out (pending[i])
        );
    end

    // Read port A: stored value, optionally overridden by the resolving write this cycle.
    always_comb begin
        OutA  = reg_data[SelA];
        BusyA = pending[SelA];
        if (BYPASS && RegWrite && (WriteAddr == SelA) && !is_zero_reg(32'(SelA))) begin
            OutA  = WriteData;
            BusyA = 1'b0;
        end
    end

    // Read port B: identical to port A, independent address.
    always_comb begin
        OutB  = reg_data[SelB];
        BusyB = pending[SelB];
        if (BYPASS && RegWrite && (WriteAddr == SelB) && !is_zero_reg(32'(SelB))) begin
            OutB  = WriteData;
            BusyB = 1'b0;
        end
    end

    // Stored scoreboard summary; a same-cycle resolving write is not reflected here.
    assign AnyBusy = |pending;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed bench for mips_regfile_sb: a default 32x32 bypassing instance and an
// 8x8 non-bypassing instance checked against a small reference model.
module tb_mips_regfile_sb;
    import mips_rf_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Default configuration (BYPASS=1).
    logic       a_we, a_mark;
    logic [4:0] a_waddr, a_maddr, a_sela, a_selb;
    rf_word_t   a_wdata, a_outa, a_outb;
    logic       a_busya, a_busyb, a_any;

    mips_regfile_sb u_dut32 (
        .clock       (clock),
        .reset       (reset),
        .RegWrite    (a_we),
        .WriteAddr   (a_waddr),
        .WriteData   (a_wdata),
        .MarkPending (a_mark),
        .MarkAddr    (a_maddr),
        .SelA        (a_sela),
        .SelB        (a_selb),
        .OutA        (a_outa),
        .OutB        (a_outb),
        .BusyA       (a_busya),
        .BusyB       (a_busyb),
        .AnyBusy     (a_any)
    );

    // Small configuration without bypass.
    logic       b_we, b_mark;
    logic [2:0] b_waddr, b_maddr, b_sela, b_selb;
    logic [7:0] b_wdata, b_outa, b_outb;
    logic       b_busya, b_busyb, b_any;

    mips_regfile_sb #(
        .DATA_WIDTH (8),
        .NUM_REGS   (8),
        .BYPASS     (1'b0)
    ) u_dut8 (
        .clock       (clock),
        .reset       (reset),
        .RegWrite    (b_we),
        .WriteAddr   (b_waddr),
        .WriteData   (b_wdata),
        .MarkPending (b_mark),
        .MarkAddr    (b_maddr),
        .SelA        (b_sela),
        .SelB        (b_selb),
        .OutA        (b_outa),
        .OutB        (b_outb),
        .BusyA       (b_busya),
        .BusyB       (b_busyb),
        .AnyBusy     (b_any)
    );

    logic [7:0] ref_data [8];
    logic [7:0] ref_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        {a_we, a_mark, a_waddr, a_maddr, a_sela, a_selb, a_wdata} = '0;
        {b_we, b_mark, b_waddr, b_maddr, b_sela, b_selb, b_wdata} = '0;

        // Reset with a write to reg 2 in the same cycle; the write must be ignored.
        reset = 1'b1; a_we = 1'b1; a_waddr = 5'd2; a_wdata = 32'h000000FF;
        a_mark = 1'b1; a_maddr = 5'd2;
        tick();
        reset = 1'b0; a_we = 1'b0; a_mark = 1'b0;
        a_sela = 5'd5; a_selb = 5'd31;
        @(negedge clock);
        check("rst_outa", a_outa, 32'h0);
        check("rst_outb", a_outb, 32'h0);
        check("rst_busya", 32'(a_busya), 32'h0);
        check("rst_busyb", 32'(a_busyb), 32'h0);
        check("rst_any", 32'(a_any), 32'h0);
        a_sela = 5'd2;
        #1;
        check("rst_ignores_write", a_outa, 32'h0);
        check("rst_ignores_mark", 32'(a_busya), 32'h0);

        // Write and mark to register 0 have no effect.
        tick();
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'hDEADBEEF;
        a_mark = 1'b1; a_maddr = 5'd0; a_sela = 5'd0;
        @(negedge clock);
        check("r0_bypass_outa", a_outa, 32'h0);
        tick();
        a_we = 1'b0; a_mark = 1'b0;
        @(negedge clock);
        check("r0_outa", a_outa, 32'h0);
        check("r0_busya", 32'(a_busya), 32'h0);
        check("r0_any", 32'(a_any), 32'h0);

        // Same-cycle bypass of a write to register 7.
        tick();
        a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h12345678; a_sela = 5'd7;
        @(negedge clock);
        check("bypass_outa", a_outa, 32'h12345678);
        tick();
        a_we = 1'b0;
        @(negedge clock);
        check("stored_outa7", a_outa, 32'h12345678);

        // Mark 9 pending, resolve it two cycles later.
        tick();
        a_mark = 1'b1; a_maddr = 5'd9; a_selb = 5'd9;
        @(negedge clock);
        check("mark9_not_yet", 32'(a_busyb), 32'h0);
        tick();
        a_mark = 1'b0;
        @(negedge clock);
        check("mark9_busyb", 32'(a_busyb), 32'h1);
        check("mark9_any", 32'(a_any), 32'h1);
        tick();
        tick();
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'hA5A5A5A5;
        @(negedge clock);
        check("resolve9_busyb", 32'(a_busyb), 32'h0);
        check("resolve9_outb", a_outb, 32'hA5A5A5A5);
        check("resolve9_any_same", 32'(a_any), 32'h1);
        tick();
        a_we = 1'b0;
        @(negedge clock);
        check("resolve9_any_next", 32'(a_any), 32'h0);
        check("resolve9_outb_next", a_outb, 32'hA5A5A5A5);

        // Simultaneous write and mark to register 4: mark wins.
        tick();
        a_we = 1'b1; a_waddr = 5'd4; a_wdata = 32'h1;
        a_mark = 1'b1; a_maddr = 5'd4; a_sela = 5'd4;
        @(negedge clock);
        check("wm4_bypass_busya", 32'(a_busya), 32'h0);
        tick();
        a_we = 1'b0; a_mark = 1'b0;
        @(negedge clock);
        check("wm4_outa", a_outa, 32'h1);
        check("wm4_busya", 32'(a_busya), 32'h1);

        // Both ports on the same register.
        a_sela = 5'd7; a_selb = 5'd7;
        #1;
        check("same_sel_outa", a_outa, 32'h12345678);
        check("same_sel_outb", a_outb, 32'h12345678);

        // Load 3 and 6, mark them, then reset discards everything.
        tick();
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
        tick();
        a_waddr = 5'd6; a_wdata = 32'h66;
        tick();
        a_we = 1'b0; a_mark = 1'b1; a_maddr = 5'd3;
        tick();
        a_maddr = 5'd6;
        tick();
        a_mark = 1'b0; a_sela = 5'd3; a_selb = 5'd6;
        @(negedge clock);
        check("pre_rst_busya3", 32'(a_busya), 32'h1);
        check("pre_rst_outb6", a_outb, 32'h66);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_any", 32'(a_any), 32'h0);
        check("post_rst_outa3", a_outa, 32'h0);
        check("post_rst_outb6", a_outb, 32'h0);
        check("post_rst_busyb6", 32'(a_busyb), 32'h0);

        // Small instance, no bypass: new value and cleared busy appear a cycle later.
        tick();
        b_mark = 1'b1; b_maddr = 3'd2;
        tick();
        b_mark = 1'b0;
        b_we = 1'b1; b_waddr = 3'd7; b_wdata = 8'h78; b_sela = 3'd7;
        b_selb = 3'd2;
        @(negedge clock);
        check("nobyp_outa_same", 32'(b_outa), 32'h0);
        check("nobyp_busyb_pending", 32'(b_busyb), 32'h1);
        tick();
        b_waddr = 3'd2; b_wdata = 8'h22;
        @(negedge clock);
        check("nobyp_outa_next", 32'(b_outa), 32'h78);
        check("nobyp_busyb_same", 32'(b_busyb), 32'h1);
        check("nobyp_outb_same", 32'(b_outb), 32'h0);
        tick();
        b_we = 1'b0;
        @(negedge clock);
        check("nobyp_busyb_next", 32'(b_busyb), 32'h0);
        check("nobyp_outb_next", 32'(b_outb), 32'h22);

        // Random traffic on the small instance against a reference array.
        for (int r = 0; r < 8; r++) ref_data[r] = 8'h0;
        ref_data[7] = 8'h78;
        ref_data[2] = 8'h22;
        ref_pend = 8'h0;
        for (int it = 0; it < 60; it++) begin
            tick();
            b_we    = 1'($urandom_range(0, 1));
            b_waddr = 3'($urandom_range(0, 7));
            b_wdata = 8'($urandom);
            b_mark  = 1'($urandom_range(0, 2) == 0);
            b_maddr = 3'($urandom_range(0, 7));
            b_sela  = 3'($urandom_range(0, 7));
            b_selb  = 3'($urandom_range(0, 7));
            @(negedge clock);
            check("rnd_outa", 32'(b_outa), 32'(ref_data[b_sela]));
            check("rnd_outb", 32'(b_outb), 32'(ref_data[b_selb]));
            check("rnd_busya", 32'(b_busya), 32'(ref_pend[b_sela]));
            check("rnd_busyb", 32'(b_busyb), 32'(ref_pend[b_selb]));
            check("rnd_any", 32'(b_any), 32'(|ref_pend));
            if (b_we && b_waddr != 3'd0) begin
                ref_data[b_waddr] = b_wdata;
                ref_pend[b_waddr] = 1'b0;
            end
            if (b_mark && b_maddr != 3'd0) ref_pend[b_maddr] = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
